// File: rtl/array_rw_ctrl.sv
// array_rw_ctrl: zero-scrub, write/read arbitration and response buffering
// for a 512x32 byte-masked SRAM macro. Optional perf counters: ARRAY_RW_PERF_CNT_EN.
module array_rw_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              mem_W0_en,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic [DATA_W-1:0] mem_W0_data,
  output logic [MASK_W-1:0] mem_W0_mask,
  output logic              mem_R0_en,
  output logic [ADDR_W-1:0] mem_R0_addr,
  input  logic [DATA_W-1:0] mem_R0_data
`ifdef ARRAY_RW_PERF_CNT_EN
  ,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          wptr_q, wptr_d;
  logic [1:0]          rptr_q, rptr_d;
  logic [DATA_W-1:0]   buf0_q, buf0_d;
  logic [DATA_W-1:0]   buf1_q, buf1_d;
  logic                inflight_q, inflight_d;
  logic [DATA_W-1:0]   fwd_data_q, fwd_data_d;
  logic [MASK_W-1:0]   fwd_mask_q, fwd_mask_d;

  logic                run;
  logic [1:0]          count;
  logic [1:0]          occ;
  logic                pop;
  logic                rd_acc;
  logic                wr_acc;
  logic [DATA_W-1:0]   bm;
  logic [DATA_W-1:0]   cap_data;

  // Scrub sequencing, arbitration, occupancy and response FIFO next-state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    inflight_d    = 1'b0;
    fwd_data_d    = fwd_data_q;
    fwd_mask_d    = '0;
    bm            = '0;
    cap_data      = '0;
    mem_W0_en     = 1'b0;
    mem_W0_addr   = wr_addr;
    mem_W0_data   = wr_data;
    mem_W0_mask   = wr_mask;

    run           = (state_q == S_RUN);
    init_done     = run;
    wr_ready      = run;
    count         = wptr_q - rptr_q;
    occ           = count + {1'b0, inflight_q};
    rd_resp_valid = (count != 2'd0);
    rd_resp_data  = rptr_q[0] ? buf1_q : buf0_q;
    pop           = rd_resp_valid & rd_resp_ready;
    rd_req_ready  = run & ((occ < 2'd2) | ((occ == 2'd2) & pop));
    rd_acc        = rd_req_valid & rd_req_ready;
    wr_acc        = wr_valid & wr_ready;
    mem_R0_en     = rd_acc;
    mem_R0_addr   = rd_req_addr;

    if (!run) begin
      // Output gated by reset_n so nothing reaches the macro while held.
      mem_W0_en   = reset_n;
      mem_W0_addr = cnt_q;
      mem_W0_data = '0;
      mem_W0_mask = '1;
      cnt_d       = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = S_RUN;
    end else begin
      mem_W0_en   = wr_acc;
    end

    // A write landing on the read address in the issue cycle is merged
    // here, so the result does not rely on the macro's collision mode.
    inflight_d = rd_acc;
    if (rd_acc && wr_acc && (wr_addr == rd_req_addr)) begin
      fwd_mask_d = wr_mask;
    end
    fwd_data_d = wr_data;

    for (int i = 0; i < MASK_W; i++) begin
      bm[8*i +: 8] = {8{fwd_mask_q[i]}};
    end
    cap_data = (mem_R0_data & ~bm) | (fwd_data_q & bm);

    if (inflight_q) begin
      if (wptr_q[0]) buf1_d = cap_data;
      else           buf0_d = cap_data;
      wptr_d = wptr_q + 2'd1;
    end
    if (pop) rptr_d = rptr_q + 2'd1;
  end

  // State, scrub counter, FIFO and in-flight registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      inflight_q <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      inflight_q <= inflight_d;
      fwd_data_q <= fwd_data_d;
      fwd_mask_q <= fwd_mask_d;
    end
  end

`ifdef ARRAY_RW_PERF_CNT_EN
  logic [31:0] perf_rd_cnt_q, perf_rd_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  // Count accepted reads and RUN cycles where a read waits.
  always_comb begin
    perf_rd_cnt_d    = perf_rd_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (rd_acc) perf_rd_cnt_d = perf_rd_cnt_q + 32'd1;
    if (run && rd_req_valid && !rd_req_ready) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_cnt_q    <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_rd_cnt_q    <= perf_rd_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_rd_cnt    = perf_rd_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: doc/array_rw_ctrl.md
Name: array_rw_ctrl

Overview:
- Request-side controller directly upstream of the 512x32 byte-masked SRAM macro (array_3_ext class); it also consumes the macro's read data.
- After reset, it zero-scrubs the whole array.
- Arbitrates a valid/ready write channel and a valid/ready read-request channel onto the macro's W0/R0 ports.
- Absorbs the macro's 1-cycle read latency in a 2-entry response buffer, so the consumer can apply backpressure without losing data.

Parameters:
- ADDR_W, 9, array address width; depth = 2^ADDR_W.
- DATA_W, 32, data width.
- MASK_W, 4, byte-mask width; DATA_W = 8*MASK_W.

Ports:
- clock  in  1  single clock; also drives the macro's W0_clk/R0_clk.
- reset_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once the scrub has completed.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid&wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_mask  in  MASK_W  byte enables.
- rd_req_valid  in  1  read request.
- rd_req_ready  out  1  read accepted when rd_req_valid&rd_req_ready.
- rd_req_addr  in  ADDR_W  read address.
- rd_resp_valid  out  1  response data valid.
- rd_resp_ready  in  1  consumer ready.
- rd_resp_data  out  DATA_W  response data.
- mem_W0_en  out  1  to macro.
- mem_W0_addr  out  ADDR_W  to macro.
- mem_W0_data  out  DATA_W  to macro.
- mem_W0_mask  out  MASK_W  to macro.
- mem_R0_en  out  1  to macro.
- mem_R0_addr  out  ADDR_W  to macro.
- mem_R0_data  in  DATA_W  from macro; valid the cycle after mem_R0_en.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - State goes to INIT; scrub counter = 0.
  - init_done, wr_ready, rd_req_ready, rd_resp_valid, mem_W0_en and mem_R0_en all 0.
  - Buffer emptied; in-flight flag cleared.
  - Reset mid-scrub or mid-read discards everything; the scrub restarts from address 0.
- FSM states:
  - INIT: each cycle drives mem_W0_en=1, addr = counter, data = 0, mask = all-ones; counter++. When counter = 2^ADDR_W-1 is written, go to RUN next cycle. Scrub takes exactly 2^ADDR_W cycles.
  - RUN: init_done=1. No other states.
- Write path (RUN):
  - wr_ready = 1.
  - Accepted write drives mem_W0_* combinationally in the same cycle; the array is updated at that clock edge.
  - mem_W0_mask = wr_mask. Mask 0 is accepted and has no effect.
- Read issue (RUN):
  - occ = buffered entries (0..2) + inflight (0/1).
  - rd_req_ready = (occ < 2), or (occ == 2 and a buffer pop happens this cycle).
  - rd_req_ready must not depend on rd_req_valid.
  - On accept: mem_R0_en=1, mem_R0_addr = rd_req_addr; inflight set for the next cycle.
- Read capture:
  - In the cycle after issue, mem_R0_data is pushed into the buffer unconditionally; capacity is guaranteed by the occupancy rule.
  - The buffer is a 2-entry FIFO with 1-bit wrap pointers.
  - rd_resp_valid = buffer non-empty. Pop on rd_resp_valid&rd_resp_ready.
  - Push and pop in the same cycle are both performed.
  - Minimum request-to-response latency is 2 cycles: issue at N, data visible at N+1, captured at the N+1 edge, rd_resp_valid at N+2.
  - With rd_resp_ready held high, one read per cycle is sustained.
- Ordering:
  - Responses are returned in request order.
  - Read and write in the same cycle to the same address: the read returns the newly written bytes (merged by mask).
  - A write accepted the cycle after a read issue does not affect that read.
- Requests presented during INIT are not accepted; valid is held by the sender.

Optional Feature:
- Macro: ARRAY_RW_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_rd_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_rd_cnt increments per accepted read.
  - perf_stall_cnt increments per RUN cycle with rd_req_valid=1 and rd_req_ready=0.
  - Both counters wrap at 2^32.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Release reset, hold requests valid → init_done rises exactly 512 cycles after the first INIT cycle; no accept before that; reads of addr 0, 255 and 511 return 0x00000000.
- Write addr 0x10 data 0xDEADBEEF mask 0xF, then write 0x11223344 mask 0x5 → read 0x10 returns 0xDE22BE44.
- Same-cycle write 0x0A0B0C0D mask 0xF and read at addr 0x20 → response 0x0A0B0C0D.
- Back-to-back reads of addr 1,2,3 with rd_resp_ready=0 → two reads accepted, third stalls. Raise ready → responses arrive in order 1,2,3 with no loss or duplication.
- Streaming 100 reads with ready=1 → one response per cycle after the 2-cycle fill.
- Assert reset_n low mid-scrub (counter=200) and during a buffered response → all outputs 0 immediately; scrub restarts at 0. With ARRAY_RW_PERF_CNT_EN defined, counters read 0 after reset and count correctly through the stall test.
